tm_engine: RTL and testbench
============================

Name: tm_engine

Overview:
- Parametrised, programmable successor to the fixed-table busy-beaver machines: one engine runs any Turing machine with up to 2^STATE_W states and 2^SYM_W symbols.
- The transition table is loaded through a rule-write port. The tape is a single-port RAM with registered read, cleared by hardware at every start.
- Reports step count, non-blank symbol count (sigma), final head position and state, and the reason the run stopped: halt, step limit, or tape overflow.
- Sits on the SPI register map as a compute peripheral; the host programs rules, starts the run, then polls done.

Parameters:
STATE_W, 1, state index width (max states = 2^STATE_W)
SYM_W, 3, symbol width (max symbols = 2^SYM_W); symbol 0 is blank
TAPE_ADDR_W, 7, tape depth = 2^TAPE_ADDR_W cells
COUNT_W, 64, width of steps and step_limit

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
rule_we  in  1  rule table write strobe; ignored while busy
rule_addr  in  STATE_W+SYM_W  {state, read symbol}
rule_wdata  in  2+SYM_W+STATE_W  {halt, newsym, dir(1=R,0=L), next}
start  in  1  one-cycle pulse begins a run; ignored while busy
step_limit  in  COUNT_W  0 = unlimited; sampled at start
busy  out  1  run in progress (clear or execute)
done  out  1  level; high from run end until next accepted start
status  out  2  0 none, 1 HALT, 2 LIMIT, 3 OVERFLOW
steps  out  COUNT_W  transitions executed in the current/last run
sigma  out  TAPE_ADDR_W+1  non-blank cells on the tape
pos  out  TAPE_ADDR_W  head position
cur_state  out  STATE_W  current machine state

Behaviour:
- Reset (async): FSM=IDLE; busy=0, done=0, status=0, steps=0, sigma=0, pos=0, cur_state=0. Tape and rule table are not reset; their contents are undefined after power-up.
- Rule table: register array of depth 2^(STATE_W+SYM_W), written synchronously on rule_we && !busy, read combinationally.
- FSM states: IDLE, CLEAR, FETCH, EXEC, DONE.
- IDLE/DONE + start:
  - Latch step_limit.
  - steps=0, sigma=0, done=0, status=0, busy=1.
  - Enter CLEAR with clear address 0.
- CLEAR:
  - Writes 0 to one cell per cycle, addresses 0..2^TAPE_ADDR_W-1.
  - After the last cell: pos = 2^(TAPE_ADDR_W-1) (centre), cur_state=0, go to FETCH.
  - Duration is exactly 2^TAPE_ADDR_W cycles.
- FETCH: issue tape read at pos; go to EXEC.
- EXEC: sym = tape read data; rule = table[{cur_state, sym}].
  - Limit check first: if step_limit!=0 && steps==step_limit, stop with status=LIMIT. Nothing is written or moved, and steps is unchanged.
  - Halt rule: steps+=1, no tape write, no move, cur_state unchanged, status=HALT.
  - Otherwise:
    - Write newsym at pos; steps+=1.
    - sigma += 1 if sym==0 && newsym!=0; sigma -= 1 if sym!=0 && newsym==0.
    - cur_state=next.
  - Move, then next step:
    - If dir=R and pos==max, or dir=L and pos==0: the write and count still occur, pos is unchanged, status=OVERFLOW. The tape never wraps.
    - Else pos ±1 and return to FETCH. Each step therefore takes 2 cycles.
- Stop: any stop sets busy=0 and done=1 on the same edge, enters DONE, and holds all outputs until the next start.
- steps saturates at all-ones; it does not wrap.
- start while busy is ignored. rule_we while busy is ignored, so the table is stable for the whole run.
- Async reset mid-run aborts immediately to IDLE. The stale tape is harmless because every start clears it.
- sym values not covered by programmed rules are whatever the table holds; the host is responsible for full programming.

Test Plan:
- BB(2,2) with STATE_W=1, SYM_W=1, TAPE_ADDR_W=4: A0=1RB, A1=1LB, B0=1LA, B1=halt; start -> done after 16 clear + 12 exec cycles; status=1, steps=6, sigma=4, pos=7, cur_state=1.
- Same machine started a second time without reset -> identical results, which proves the tape is cleared.
- Overflow, TAPE_ADDR_W=4, A0=1RA: start -> status=3, steps=8, sigma=8, pos=15.
- Limit: 2-state 5-symbol machine 1RB 4LA 1LA halt 2RB / 2LB 3LA 1LB 2RA 0RB, TAPE_ADDR_W=9, step_limit=1000 -> status=2, steps=1000, busy=0. Separately, step_limit=0 with the BB(2,2) table -> normal HALT, steps=6.
- Busy guards: during a run, pulse start and write rule A0=0RA -> the run completes unchanged (BB(2,2) values); after done, a read-back run shows the write was dropped.
- Reset at cycle 20 of a run -> same cycle busy=0, done=0, status=0, steps=0; a subsequent start yields a correct full run.

Source files
------------

// File: rtl/tm_engine.sv
// Programmable Turing-machine engine: the host loads a rule table, then each run clears the tape
// and executes FETCH/EXEC steps until the machine halts, hits the step limit or runs off the tape.
module tm_engine #(
    parameter int STATE_W     = 1,
    parameter int SYM_W       = 3,
    parameter int TAPE_ADDR_W = 7,
    parameter int COUNT_W     = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rule_we,
    input  logic [STATE_W+SYM_W-1:0]   rule_addr,
    input  logic [2+SYM_W+STATE_W-1:0] rule_wdata,
    input  logic                       start,
    input  logic [COUNT_W-1:0]         step_limit,
    output logic                       busy,
    output logic                       done,
    output logic [1:0]                 status,
    output logic [COUNT_W-1:0]         steps,
    output logic [TAPE_ADDR_W:0]       sigma,
    output logic [TAPE_ADDR_W-1:0]     pos,
    output logic [STATE_W-1:0]         cur_state
);
    localparam int RULE_AW    = STATE_W + SYM_W;
    localparam int RULE_W     = 2 + SYM_W + STATE_W;
    localparam int RULE_DEPTH = 1 << RULE_AW;
    localparam int CELLS      = 1 << TAPE_ADDR_W;
    localparam logic [TAPE_ADDR_W-1:0] POS_CENTRE = TAPE_ADDR_W'(CELLS / 2);
    localparam logic [TAPE_ADDR_W-1:0] POS_MAX    = TAPE_ADDR_W'(CELLS - 1);
    localparam logic [1:0] ST_NONE = 2'd0;
    localparam logic [1:0] ST_HALT = 2'd1;
    localparam logic [1:0] ST_LIM  = 2'd2;
    localparam logic [1:0] ST_OVF  = 2'd3;

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FETCH, S_EXEC, S_DONE} fsm_e;

    fsm_e                   fsm_q, fsm_d;
    logic [COUNT_W-1:0]     limit_q, limit_d;
    logic [COUNT_W-1:0]     steps_q, steps_d;
    logic [TAPE_ADDR_W:0]   sigma_q, sigma_d;
    logic [TAPE_ADDR_W-1:0] pos_q, pos_d;
    logic [TAPE_ADDR_W-1:0] clr_q, clr_d;
    logic [STATE_W-1:0]     cur_q, cur_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [1:0]             status_q, status_d;

    logic [RULE_W-1:0]      rule_mem [RULE_DEPTH];
    logic [SYM_W-1:0]       tape_mem [CELLS];
    logic [SYM_W-1:0]       rdata_q;

    logic [RULE_W-1:0]      rule_s;
    logic                   rule_halt_s;
    logic [SYM_W-1:0]       rule_sym_s;
    logic                   rule_dir_s;
    logic [STATE_W-1:0]     rule_next_s;
    logic [COUNT_W-1:0]     steps_inc_s;
    logic [TAPE_ADDR_W-1:0] tape_addr_s;
    logic                   tape_we_s;
    logic [SYM_W-1:0]       tape_wdata_s;

    assign rule_s      = rule_mem[{cur_q, rdata_q}];
    assign rule_halt_s = rule_s[RULE_W-1];
    assign rule_sym_s  = rule_s[RULE_W-2 -: SYM_W];
    assign rule_dir_s  = rule_s[STATE_W];
    assign rule_next_s = rule_s[STATE_W-1:0];
    assign steps_inc_s = (&steps_q) ? steps_q : steps_q + COUNT_W'(1);
    assign tape_addr_s = (fsm_q == S_CLEAR) ? clr_q : pos_q;

    // Rule table write port, frozen while a run is in progress
    always_ff @(posedge clk) begin
        if (rule_we && !busy_q) begin
            rule_mem[rule_addr] <= rule_wdata;
        end
    end

    // Single-port tape RAM with registered read data
    always_ff @(posedge clk) begin
        if (tape_we_s) begin
            tape_mem[tape_addr_s] <= tape_wdata_s;
        end
        rdata_q <= tape_mem[tape_addr_s];
    end

    // Next-state logic for the run controller
    always_comb begin
        fsm_d        = fsm_q;
        limit_d      = limit_q;
        steps_d      = steps_q;
        sigma_d      = sigma_q;
        pos_d        = pos_q;
        clr_d        = clr_q;
        cur_d        = cur_q;
        busy_d       = busy_q;
        done_d       = done_q;
        status_d     = status_q;
        tape_we_s    = 1'b0;
        tape_wdata_s = '0;
        case (fsm_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    limit_d  = step_limit;
                    steps_d  = '0;
                    sigma_d  = '0;
                    done_d   = 1'b0;
                    status_d = ST_NONE;
                    busy_d   = 1'b1;
                    clr_d    = '0;
                    fsm_d    = S_CLEAR;
                end else begin
                    fsm_d = fsm_q;
                end
            end
            S_CLEAR: begin
                tape_we_s = 1'b1;
                clr_d     = clr_q + TAPE_ADDR_W'(1);
                if (clr_q == POS_MAX) begin
                    pos_d = POS_CENTRE;
                    cur_d = '0;
                    fsm_d = S_FETCH;
                end else begin
                    fsm_d = S_CLEAR;
                end
            end
            S_FETCH: begin
                fsm_d = S_EXEC;
            end
            S_EXEC: begin
                // The limit check precedes the rule so a limited run never executes step limit+1
                if ((limit_q != '0) && (steps_q == limit_q)) begin
                    status_d = ST_LIM;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    fsm_d    = S_DONE;
                end else if (rule_halt_s) begin
                    steps_d  = steps_inc_s;
                    status_d = ST_HALT;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    fsm_d    = S_DONE;
                end else begin
                    tape_we_s    = 1'b1;
                    tape_wdata_s = rule_sym_s;
                    steps_d      = steps_inc_s;
                    cur_d        = rule_next_s;
                    if ((rdata_q == '0) && (rule_sym_s != '0)) begin
                        sigma_d = sigma_q + (TAPE_ADDR_W+1)'(1);
                    end else if ((rdata_q != '0) && (rule_sym_s == '0)) begin
                        sigma_d = sigma_q - (TAPE_ADDR_W+1)'(1);
                    end else begin
                        sigma_d = sigma_q;
                    end
                    if ((rule_dir_s && (pos_q == POS_MAX)) || (!rule_dir_s && (pos_q == '0))) begin
                        status_d = ST_OVF;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        fsm_d    = S_DONE;
                    end else if (rule_dir_s) begin
                        pos_d = pos_q + TAPE_ADDR_W'(1);
                        fsm_d = S_FETCH;
                    end else begin
                        pos_d = pos_q - TAPE_ADDR_W'(1);
                        fsm_d = S_FETCH;
                    end
                end
            end
            default: begin
                fsm_d  = S_IDLE;
                busy_d = 1'b0;
            end
        endcase
    end

    // Controller and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q    <= S_IDLE;
            limit_q  <= '0;
            steps_q  <= '0;
            sigma_q  <= '0;
            pos_q    <= '0;
            clr_q    <= '0;
            cur_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            status_q <= ST_NONE;
        end else begin
            fsm_q    <= fsm_d;
            limit_q  <= limit_d;
            steps_q  <= steps_d;
            sigma_q  <= sigma_d;
            pos_q    <= pos_d;
            clr_q    <= clr_d;
            cur_q    <= cur_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            status_q <= status_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign status    = status_q;
    assign steps     = steps_q;
    assign sigma     = sigma_q;
    assign pos       = pos_q;
    assign cur_state = cur_q;
endmodule

// File: tb/tb_tm_engine.sv
// Bench for tm_engine: two instances (16-cell and 512-cell tapes) share the host inputs and are
// compared against a plain tape-simulation model for directed and random machines.
module tb_tm_engine;
    localparam int SW  = 1;
    localparam int YW  = 3;
    localparam int CW  = 64;
    localparam int AWA = 4;
    localparam int AWB = 9;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rule_we;
    logic [3:0]    rule_addr;
    logic [5:0]    rule_wdata;
    logic          start;
    logic [63:0]   step_limit;

    logic          busy_a, done_a, busy_b, done_b;
    logic [1:0]    status_a, status_b;
    logic [63:0]   steps_a, steps_b;
    logic [AWA:0]  sigma_a;
    logic [AWB:0]  sigma_b;
    logic [AWA-1:0] pos_a;
    logic [AWB-1:0] pos_b;
    logic          cur_a, cur_b;

    tm_engine #(.STATE_W(SW), .SYM_W(YW), .TAPE_ADDR_W(AWA), .COUNT_W(CW)) u_small (
        .clk(clk), .rst_n(rst_n), .rule_we(rule_we), .rule_addr(rule_addr),
        .rule_wdata(rule_wdata), .start(start), .step_limit(step_limit),
        .busy(busy_a), .done(done_a), .status(status_a), .steps(steps_a),
        .sigma(sigma_a), .pos(pos_a), .cur_state(cur_a)
    );

    tm_engine #(.STATE_W(SW), .SYM_W(YW), .TAPE_ADDR_W(AWB), .COUNT_W(CW)) u_big (
        .clk(clk), .rst_n(rst_n), .rule_we(rule_we), .rule_addr(rule_addr),
        .rule_wdata(rule_wdata), .start(start), .step_limit(step_limit),
        .busy(busy_b), .done(done_b), .status(status_b), .steps(steps_b),
        .sigma(sigma_b), .pos(pos_b), .cur_state(cur_b)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic [5:0] rules_m [16];
    int m_status [2];
    int m_steps  [2];
    int m_sigma  [2];
    int m_pos    [2];
    int m_state  [2];
    int m_cycles [2];

    function automatic logic [5:0] enc(input bit h, input int ns, input bit d, input int nx);
        logic [2:0] ns3;
        logic       nx1;
        ns3 = 3'(ns);
        nx1 = 1'(nx);
        return {h, ns3, d, nx1};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic put_rule(input int a, input logic [5:0] r);
        rule_we    = 1'b1;
        rule_addr  = 4'(a);
        rule_wdata = r;
        rules_m[a] = r;
        @(negedge clk);
        rule_we = 1'b0;
    endtask

    task automatic program_halts();
        for (int a = 0; a < 16; a++) put_rule(a, enc(1'b1, 0, 1'b0, 0));
    endtask

    task automatic program_bb22();
        program_halts();
        put_rule(0, enc(1'b0, 1, 1'b1, 1));
        put_rule(1, enc(1'b0, 1, 1'b0, 1));
        put_rule(8, enc(1'b0, 1, 1'b0, 0));
        put_rule(9, enc(1'b1, 0, 1'b0, 0));
    endtask

    // Straightforward simulation of the machine on a finite, non-wrapping tape
    task automatic model_run(input int idx, input int aw, input longint unsigned lim);
        int tp [512];
        int cells, p, st, stp, sg, iters, sym, ns, stat;
        logic [5:0] r;
        cells = 1 << aw;
        p = cells / 2;
        st = 0; stp = 0; sg = 0; iters = 0; stat = 0;
        for (int i = 0; i < 512; i++) tp[i] = 0;
        for (int k = 0; k < 100000; k++) begin
            iters++;
            if (lim != 0 && longint'(stp) == longint'(lim)) begin stat = 2; break; end
            sym = tp[p];
            r = rules_m[st * 8 + sym];
            stp++;
            if (r[5]) begin stat = 1; break; end
            ns = int'(r[4:2]);
            if (sym == 0 && ns != 0) sg++;
            else if (sym != 0 && ns == 0) sg--;
            tp[p] = ns;
            st = int'(r[0]);
            if ((r[1] && p == cells - 1) || (!r[1] && p == 0)) begin stat = 3; break; end
            p = r[1] ? p + 1 : p - 1;
        end
        m_status[idx] = stat;
        m_steps[idx]  = stp;
        m_sigma[idx]  = sg;
        m_pos[idx]    = p;
        m_state[idx]  = st;
        m_cycles[idx] = cells + 2 * iters;
    endtask

    task automatic cmp_inst(input string tag, input int i, input int lat, input logic bz,
                            input logic dn, input logic [1:0] stt, input logic [63:0] stp,
                            input int sg, input int p, input logic cs);
        chk({tag, ".latency"}, 64'(lat), 64'(m_cycles[i]));
        chk({tag, ".status"},  64'(stt), 64'(m_status[i]));
        chk({tag, ".steps"},   stp,      64'(m_steps[i]));
        chk({tag, ".sigma"},   64'(sg),  64'(m_sigma[i]));
        chk({tag, ".pos"},     64'(p),   64'(m_pos[i]));
        chk({tag, ".state"},   64'(cs),  64'(m_state[i]));
        chk({tag, ".busy"},    64'(bz),  64'd0);
        chk({tag, ".done"},    64'(dn),  64'd1);
    endtask

    task automatic run_check(input string tag, input longint unsigned lim, input bit inject);
        int lat [2];
        model_run(0, AWA, lim);
        model_run(1, AWB, lim);
        step_limit = lim;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, ".busy_at_start"}, {62'd0, busy_b, busy_a}, 64'd3);
        chk({tag, ".done_at_start"}, {62'd0, done_b, done_a}, 64'd0);
        lat[0] = -1;
        lat[1] = -1;
        for (int n = 0; n < 6000 && (lat[0] < 0 || lat[1] < 0); n++) begin
            if (inject && n == 5) begin
                start = 1'b1; rule_we = 1'b1; rule_addr = 4'd0; rule_wdata = 6'b000010;
            end else if (inject && n == 6) begin
                start = 1'b0; rule_we = 1'b0;
            end
            if (done_a && lat[0] < 0) lat[0] = n;
            if (done_b && lat[1] < 0) lat[1] = n;
            if (lat[0] < 0 || lat[1] < 0) @(negedge clk);
        end
        start = 1'b0;
        rule_we = 1'b0;
        cmp_inst({tag, ".small"}, 0, lat[0], busy_a, done_a, status_a, steps_a,
                 int'(sigma_a), int'(pos_a), cur_a);
        cmp_inst({tag, ".big"}, 1, lat[1], busy_b, done_b, status_b, steps_b,
                 int'(sigma_b), int'(pos_b), cur_b);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; rule_we = 1'b0; rule_addr = '0; rule_wdata = '0;
        start = 1'b0; step_limit = '0;
        repeat (3) @(negedge clk);
        chk("reset.busy",   {62'd0, busy_b, busy_a}, 64'd0);
        chk("reset.done",   {62'd0, done_b, done_a}, 64'd0);
        chk("reset.status", {60'd0, status_b, status_a}, 64'd0);
        chk("reset.steps",  steps_a | steps_b, 64'd0);
        chk("reset.sigma",  64'(sigma_a) | 64'(sigma_b), 64'd0);
        chk("reset.pos",    64'(pos_a) | 64'(pos_b), 64'd0);
        chk("reset.state",  {62'd0, cur_b, cur_a}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        program_bb22();
        run_check("bb22", 0, 1'b0);
        chk("bb22.plan_steps", steps_a, 64'd6);
        chk("bb22.plan_pos",   64'(pos_a), 64'd7);
        run_check("bb22_again", 0, 1'b0);
        run_check("busy_guard", 0, 1'b1);
        run_check("readback", 0, 1'b0);

        put_rule(0, enc(1'b0, 1, 1'b1, 0));
        run_check("overflow", 0, 1'b0);
        chk("overflow.plan_status", 64'(status_a), 64'd3);
        chk("overflow.plan_sigma",  64'(sigma_a), 64'd8);

        program_halts();
        put_rule(0,  enc(1'b0, 1, 1'b1, 1));
        put_rule(1,  enc(1'b0, 4, 1'b0, 0));
        put_rule(2,  enc(1'b0, 1, 1'b0, 0));
        put_rule(3,  enc(1'b1, 0, 1'b0, 0));
        put_rule(4,  enc(1'b0, 2, 1'b1, 1));
        put_rule(8,  enc(1'b0, 2, 1'b0, 1));
        put_rule(9,  enc(1'b0, 3, 1'b0, 0));
        put_rule(10, enc(1'b0, 1, 1'b0, 1));
        put_rule(11, enc(1'b0, 2, 1'b1, 0));
        put_rule(12, enc(1'b0, 0, 1'b1, 1));
        run_check("limit", 1000, 1'b0);

        program_bb22();
        run_check("unlimited", 0, 1'b0);

        step_limit = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset.busy",   {62'd0, busy_b, busy_a}, 64'd0);
        chk("midreset.done",   {62'd0, done_b, done_a}, 64'd0);
        chk("midreset.status", {60'd0, status_b, status_a}, 64'd0);
        chk("midreset.steps",  steps_a | steps_b, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_check("after_reset", 0, 1'b0);

        for (int t = 0; t < 6; t++) begin
            for (int a = 0; a < 16; a++) begin
                put_rule(a, enc($urandom_range(0, 7) == 0, int'($urandom_range(0, 7)),
                                1'($urandom_range(0, 1)), int'($urandom_range(0, 1))));
            end
            run_check($sformatf("random%0d", t), longint'($urandom_range(1, 200)), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
